// File: rtl/isa_pkg.sv
// Shared ISA definitions for the six-instruction datapath and its
// instruction-memory loader: opcode encodings and the loader state type.
package isa_pkg;

   localparam logic [3:0] OP_MOVL = 4'h0;
   localparam logic [3:0] OP_MOVS = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_MOVI = 4'h3;
   localparam logic [3:0] OP_SUB  = 4'h4;
   localparam logic [3:0] OP_JMPZ = 4'h5;
   localparam logic [3:0] MAX_OP  = OP_JMPZ;

   typedef enum logic [2:0] {
      CNT_HI,
      CNT_LO,
      DAT_HI,
      DAT_LO,
      LOADED,
      ERROR
   } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
// The master side is the loader itself; the slave side is the stream source plus memory.
interface imem_loader_if #(parameter int ADDR_W = 8);

   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [15:0]       imem_wdata;

   modport master (
      input  in_data, in_valid,
      output in_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      output in_data, in_valid,
      input  in_ready, imem_we, imem_addr, imem_wdata
   );

endinterface

// File: rtl/imem_loader.sv
// Receives a length-prefixed byte stream, assembles 16-bit instruction words,
// writes them into instruction memory and holds the CPU in reset until done.
module imem_loader #(
   parameter int         ADDR_W = 8,
   parameter logic [3:0] MAX_OP = isa_pkg::MAX_OP
) (
   input  logic         clk,
   input  logic         reset,
   imem_loader_if.master bus,
   input  logic         restart,
   output logic         cpu_hold,
   output logic         done,
   output logic         len_err,
   output logic         op_err
);

   import isa_pkg::*;

   localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

   loader_state_t     r_state, w_stateNext;
   logic [15:0]       r_count, w_countNext;
   logic [15:0]       r_index, w_indexNext;
   logic [7:0]        r_hi, w_hiNext;
   logic              r_inReady, w_inReadyNext;
   logic              r_we, w_weNext;
   logic [ADDR_W-1:0] r_addr, w_addrNext;
   logic [15:0]       r_wdata, w_wdataNext;
   logic              r_done, w_doneNext;
   logic              r_cpuHold;
   logic              r_lenErr, w_lenErrNext;
   logic              r_opErr, w_opErrNext;
   logic              w_xfer;
   logic [15:0]       w_countFull;

   // Next-state and next-output logic; every register output is computed here
   always_comb begin
      w_stateNext   = r_state;
      w_countNext   = r_count;
      w_indexNext   = r_index;
      w_hiNext      = r_hi;
      w_weNext      = 1'b0;
      w_addrNext    = r_addr;
      w_wdataNext   = r_wdata;
      w_lenErrNext  = r_lenErr;
      w_opErrNext   = r_opErr;
      w_xfer        = bus.in_valid && r_inReady;
      w_countFull   = {r_count[15:8], bus.in_data};

      case (r_state)
         CNT_HI: begin
            if (w_xfer) begin
               w_countNext[15:8] = bus.in_data;
               w_stateNext       = CNT_LO;
            end
         end
         CNT_LO: begin
            if (w_xfer) begin
               w_countNext = w_countFull;
               w_indexNext = 16'd0;
               if (w_countFull == 16'd0) begin
                  w_stateNext = LOADED;
               end else if ({1'b0, w_countFull} > CAPACITY) begin
                  w_stateNext  = ERROR;
                  w_lenErrNext = 1'b1;
               end else begin
                  w_stateNext = DAT_HI;
               end
            end
         end
         DAT_HI: begin
            if (w_xfer) begin
               w_hiNext    = bus.in_data;
               w_stateNext = DAT_LO;
            end
         end
         DAT_LO: begin
            if (w_xfer) begin
               w_weNext    = 1'b1;
               w_addrNext  = r_index[ADDR_W-1:0];
               w_wdataNext = {r_hi, bus.in_data};
               w_indexNext = r_index + 16'd1;
               if (r_hi[7:4] > MAX_OP) begin
                  w_opErrNext = 1'b1;
               end
               w_stateNext = ((r_index + 16'd1) == r_count) ? LOADED : DAT_HI;
            end
         end
         LOADED, ERROR: begin
            if (restart) begin
               w_stateNext  = CNT_HI;
               w_indexNext  = 16'd0;
               w_lenErrNext = 1'b0;
               w_opErrNext  = 1'b0;
            end
         end
         default: begin
            w_stateNext = CNT_HI;
         end
      endcase

      w_inReadyNext = (w_stateNext != LOADED) && (w_stateNext != ERROR);
      // done lags entry into LOADED by a cycle so the CPU is released only after the last write lands
      w_doneNext    = (r_state == LOADED) && (w_stateNext == LOADED);
   end

   // State and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= CNT_HI;
         r_count   <= 16'd0;
         r_index   <= 16'd0;
         r_hi      <= 8'd0;
         r_inReady <= 1'b1;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= 16'd0;
         r_done    <= 1'b0;
         r_cpuHold <= 1'b1;
         r_lenErr  <= 1'b0;
         r_opErr   <= 1'b0;
      end else begin
         r_state   <= w_stateNext;
         r_count   <= w_countNext;
         r_index   <= w_indexNext;
         r_hi      <= w_hiNext;
         r_inReady <= w_inReadyNext;
         r_we      <= w_weNext;
         r_addr    <= w_addrNext;
         r_wdata   <= w_wdataNext;
         r_done    <= w_doneNext;
         r_cpuHold <= !w_doneNext;
         r_lenErr  <= w_lenErrNext;
         r_opErr   <= w_opErrNext;
      end
   end

   assign bus.in_ready   = r_inReady;
   assign bus.imem_we    = r_we;
   assign bus.imem_addr  = r_addr;
   assign bus.imem_wdata = r_wdata;
   assign cpu_hold       = r_cpuHold;
   assign done           = r_done;
   assign len_err        = r_lenErr;
   assign op_err         = r_opErr;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: streams small programs and compares every
// memory write and status flag against hand-computed values.
module tb_imem_loader;

   logic clk = 1'b0;
   logic reset;
   logic restart;
   logic cpu_hold, done, len_err, op_err;

   imem_loader_if #(.ADDR_W(8)) bus();

   imem_loader #(.ADDR_W(8), .MAX_OP(4'h5)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .restart  (restart),
      .cpu_hold (cpu_hold),
      .done     (done),
      .len_err  (len_err),
      .op_err   (op_err)
   );

   always #5 clk = ~clk;

   int checkCount = 0;
   int errorCount = 0;
   int wrCount    = 0;
   logic [7:0]  wrAddr [16];
   logic [15:0] wrData [16];
   logic [7:0]  stream [$];

   // Log every write strobe once per pulse, sampled mid-cycle
   always @(negedge clk) begin
      if (bus.imem_we) begin
         if (wrCount < 16) begin
            wrAddr[wrCount] = bus.imem_addr;
            wrData[wrCount] = bus.imem_wdata;
         end
         wrCount++;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b, input int gap);
      int waitCycles = 0;
      repeat (gap) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
      end
      @(negedge clk);
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && waitCycles < 50) begin
         @(negedge clk);
         waitCycles++;
      end
      if (!bus.in_ready) begin
         checkOutput("ready_timeout", 32'(bus.in_ready), 32'd1);
         bus.in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic sendStream(input int maxGap);
      for (int i = 0; i < stream.size(); i++) begin
         applyStimulus(stream[i], (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0);
      end
   endtask

   task automatic restartPulse();
      @(negedge clk);
      restart = 1'b1;
      @(posedge clk);
      #1 restart = 1'b0;
      checkOutput("restart_cpu_hold", 32'(cpu_hold), 32'd1);
      checkOutput("restart_done", 32'(done), 32'd0);
      checkOutput("restart_in_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("restart_len_err", 32'(len_err), 32'd0);
      checkOutput("restart_op_err", 32'(op_err), 32'd0);
   endtask

   // Program 1: three words, the last with opcode 5 (legal boundary)
   task automatic runProg1(input int maxGap);
      wrCount = 0;
      stream = '{8'h00, 8'h03, 8'h30, 8'h05, 8'h20, 8'h12, 8'h50, 8'h04};
      sendStream(maxGap);
      checkOutput("p1_last_we", 32'(bus.imem_we), 32'd1);
      checkOutput("p1_last_addr", 32'(bus.imem_addr), 32'd2);
      checkOutput("p1_last_wdata", 32'(bus.imem_wdata), 32'h5004);
      checkOutput("p1_hold_during_pulse", 32'(cpu_hold), 32'd1);
      checkOutput("p1_done_during_pulse", 32'(done), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("p1_cpu_hold", 32'(cpu_hold), 32'd0);
      checkOutput("p1_done", 32'(done), 32'd1);
      checkOutput("p1_we_low", 32'(bus.imem_we), 32'd0);
      checkOutput("p1_in_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("p1_op_err", 32'(op_err), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("p1_write_count", 32'(wrCount), 32'd3);
      checkOutput("p1_addr0", 32'(wrAddr[0]), 32'd0);
      checkOutput("p1_data0", 32'(wrData[0]), 32'h3005);
      checkOutput("p1_addr1", 32'(wrAddr[1]), 32'd1);
      checkOutput("p1_data1", 32'(wrData[1]), 32'h2012);
      checkOutput("p1_addr2", 32'(wrAddr[2]), 32'd2);
      checkOutput("p1_data2", 32'(wrData[2]), 32'h5004);
   endtask

   task automatic checkResetValues(input string phase);
      checkOutput({phase, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      checkOutput({phase, "_we"}, 32'(bus.imem_we), 32'd0);
      checkOutput({phase, "_addr"}, 32'(bus.imem_addr), 32'd0);
      checkOutput({phase, "_wdata"}, 32'(bus.imem_wdata), 32'd0);
      checkOutput({phase, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
      checkOutput({phase, "_done"}, 32'(done), 32'd0);
      checkOutput({phase, "_len_err"}, 32'(len_err), 32'd0);
      checkOutput({phase, "_op_err"}, 32'(op_err), 32'd0);
   endtask

   initial begin
      reset        = 1'b1;
      restart      = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      repeat (3) @(negedge clk);
      checkResetValues("rst");
      reset = 1'b0;
      @(negedge clk);
      checkResetValues("idle");

      $display("[TB] program of three words, no gaps");
      runProg1(0);
      restartPulse();

      $display("[TB] empty program");
      wrCount = 0;
      stream = '{8'h00, 8'h00};
      sendStream(0);
      checkOutput("n0_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("n0_done", 32'(done), 32'd1);
      checkOutput("n0_cpu_hold", 32'(cpu_hold), 32'd0);
      checkOutput("n0_write_count", 32'(wrCount), 32'd0);
      restartPulse();

      $display("[TB] length exceeds capacity");
      wrCount = 0;
      stream = '{8'h01, 8'h01};
      sendStream(0);
      checkOutput("len_len_err", 32'(len_err), 32'd1);
      checkOutput("len_in_ready", 32'(bus.in_ready), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("len_cpu_hold", 32'(cpu_hold), 32'd1);
      checkOutput("len_done", 32'(done), 32'd0);
      checkOutput("len_write_count", 32'(wrCount), 32'd0);
      restartPulse();

      $display("[TB] illegal opcode");
      wrCount = 0;
      stream = '{8'h00, 8'h01, 8'h90, 8'h00};
      sendStream(0);
      checkOutput("op_we", 32'(bus.imem_we), 32'd1);
      checkOutput("op_addr", 32'(bus.imem_addr), 32'd0);
      checkOutput("op_wdata", 32'(bus.imem_wdata), 32'h9000);
      checkOutput("op_err_set", 32'(op_err), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("op_err_sticky", 32'(op_err), 32'd1);
      checkOutput("op_done", 32'(done), 32'd1);
      checkOutput("op_write_count", 32'(wrCount), 32'd1);

      $display("[TB] restart with a byte offered in the same cycle");
      @(negedge clk);
      restart      = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hAA;
      @(posedge clk);
      #1;
      restart      = 1'b0;
      bus.in_valid = 1'b0;
      checkOutput("coll_in_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("coll_op_err", 32'(op_err), 32'd0);
      wrCount = 0;
      stream = '{8'h00, 8'h01, 8'h30, 8'h05};
      sendStream(0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("coll_done", 32'(done), 32'd1);
      checkOutput("coll_write_count", 32'(wrCount), 32'd1);
      checkOutput("coll_data0", 32'(wrData[0]), 32'h3005);
      restartPulse();

      $display("[TB] program of three words with random valid gaps");
      runProg1(5);
      restartPulse();

      $display("[TB] full-capacity header then reset mid-load");
      stream = '{8'h01, 8'h00, 8'h30, 8'h05, 8'h20, 8'h12};
      sendStream(0);
      checkOutput("cap_len_err", 32'(len_err), 32'd0);
      checkOutput("cap_in_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("cap_we", 32'(bus.imem_we), 32'd1);
      checkOutput("cap_addr", 32'(bus.imem_addr), 32'd1);
      #2 reset = 1'b1;
      #1;
      checkResetValues("async");
      @(negedge clk);
      reset = 1'b0;
      runProg1(0);

      $display("[TB] Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
